id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand forwarding for the 16-bit pipelined processor.
- Sits directly upstream of the ALU: latches decoded operands and control, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's in1, in2 and control inputs.
- Also flags load-use hazards to the hazard unit.

Parameters:
W, 16, datapath width; must equal the ALU width.
RA_W, 3, register address width (R0-R7, all general-purpose, no hardwired zero).
OP_W, 1, ALU control width; matches the ALU controlSignal.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold EX-stage instruction; forward-capture operands (see Behaviour)
flush  in  1  replace EX-stage instruction with a bubble
id_valid  in  1  decode stage holds a real instruction
id_src1_en, id_src2_en  in  1 each  instruction reads src1 / src2
id_src1_addr, id_src2_addr, id_dst_addr  in  RA_W each  register addresses
id_src1_val, id_src2_val  in  W each  register-file read data
id_imm  in  W  sign-extended immediate
id_use_imm  in  1  ALU in2 takes the immediate
id_alu_op  in  OP_W  ALU control
id_wb_en, id_mem_rd, id_mem_wr, id_flags_en  in  1 each  downstream control
exm_wb_en, exm_mem_rd  in  1 each  EX/MEM control
exm_dst_addr  in  RA_W
exm_result  in  W  EX/MEM ALU result
mwb_wb_en  in  1
mwb_dst_addr  in  RA_W
mwb_data  in  W  final write-back data (ALU result or load data)
alu_in1, alu_in2  out  W each  to ALU
alu_op  out  OP_W  to ALU controlSignal
ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_flags_en  out  1 each
ex_dst_addr  out  RA_W
ex_store_data  out  W  forwarded src2 value, used as store data
load_use_hazard  out  1  combinational, to hazard unit

Behaviour:
- Reset (rst=1 at edge): all registers 0. Outputs: ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr and ex_flags_en are 0; alu_op is 0; alu_in1, alu_in2 and ex_store_data are 0 unless forwarding applies; load_use_hazard is 0.
- Update priority at each edge: rst > flush > stall > load.
  - flush: valid and all control bits cleared, data fields cleared to 0. Flush wins over a simultaneous stall.
  - stall: control, addresses, imm and alu_op held. Operand registers s1/s2 reload with their current forwarded values (forward-capture), so a producer retiring past WB during the stall is not lost.
  - load: all fields taken from id_*. Each operand is write-bypassed: if mwb_wb_en and mwb_dst_addr equals the src address, latch mwb_data instead of id_srcN_val (register-file same-cycle write not visible to the read).
- Forwarding (combinational, per operand N, only if ex_valid and srcN_en registered):
  - 1st priority: exm_wb_en & !exm_mem_rd & exm_dst_addr==srcN_addr -> exm_result.
  - 2nd priority: mwb_wb_en & mwb_dst_addr==srcN_addr -> mwb_data.
  - Otherwise: registered sN.
  - A load sitting in EX/MEM is never forwarded; the load-use stall guarantees it has moved to MEM/WB first.
- Operand outputs: alu_in1 = fwd1. alu_in2 = use_imm ? imm : fwd2. ex_store_data = fwd2 always.
- load_use_hazard = ex_valid & ex_mem_rd & id_valid & ((id_src1_en & id_src1_addr==ex_dst_addr) | (id_src2_en & id_src2_addr==ex_dst_addr)). Forced to 0 during rst.
- Expected hazard-unit response to load_use_hazard: stall IF/ID and flush this stage for one cycle.
- Latency: one cycle from ID inputs to EX outputs. Operand forwarding has zero added cycles.
- Reset mid-stall or mid-flush: rst dominates; the next cycle is a bubble.

Decomposition:
- Shared package proc_pkg holds W, RA_W, OP_W, the ALU op encodings, and the control-bundle field order.
- One natural sub-module, fwd_sel: a combinational 3-way operand select with the priority rules above. It is instantiated twice, once per operand, and its output feeds both the output mux and the forward-capture path.

Test Plan:
- Back-to-back ALU RAW: EX/MEM writes R2=0x0005; ID reads src1=R2 with stale 0x0001 -> alu_in1=0x0005 in the EX cycle.
- Double hazard: EX/MEM R3=0xFFFF and MEM/WB R3=0x1234 both valid -> alu_in1=0xFFFF (EX/MEM wins).
- Load-use: EX holds a load to R4, ID reads R4 -> load_use_hazard=1. Bench applies stall+flush. Next cycle MEM/WB R4=0xBEEF -> alu_in2=0xBEEF, hazard=0.
- Stall forward-capture: producer R1=0x00AA in MEM/WB during a 2-cycle stall, then retires -> alu_in1 remains 0x00AA after the stall.
- Write bypass at load: mwb writes R5=0x7777 in the same cycle ID reads R5=0x0000 -> s1 latches 0x7777.
- Flush vs stall and reset: flush=1 with stall=1 -> ex_valid=0 and all ctrl 0 next cycle. rst=1 mid-stream -> all control outputs 0 and alu_op=0 next cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the 16-bit pipelined processor.
// Holds datapath widths, ALU op encodings and the ID/EX bundle layout.
package proc_pkg;

  localparam int W    = 16;
  localparam int RA_W = 3;
  localparam int OP_W = 1;

  localparam logic [OP_W-1:0] ALU_ADD  = 1'b0;
  localparam logic [OP_W-1:0] ALU_NAND = 1'b1;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_rd;
    logic mem_wr;
    logic flags_en;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [OP_W-1:0] alu_op;
    logic            use_imm;
    logic            src1_en;
    logic            src2_en;
    logic [RA_W-1:0] src1_addr;
    logic [RA_W-1:0] src2_addr;
    logic [RA_W-1:0] dst_addr;
    logic [W-1:0]    imm;
    logic [W-1:0]    s1;
    logic [W-1:0]    s2;
  } id_ex_t;

  function automatic logic hit(
    input logic            en,
    input logic [RA_W-1:0] a,
    input logic [RA_W-1:0] b
  );
    return en && (a == b);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Three-way operand select: EX/MEM result, then MEM/WB data,
// then the registered operand. Loads in EX/MEM never forward.
module fwd_sel
  import proc_pkg::*;
(
  input  logic            en_i,
  input  logic [RA_W-1:0] addr_i,
  input  logic [W-1:0]    reg_i,
  input  logic            exm_wb_en_i,
  input  logic            exm_mem_rd_i,
  input  logic [RA_W-1:0] exm_dst_i,
  input  logic [W-1:0]    exm_res_i,
  input  logic            mwb_wb_en_i,
  input  logic [RA_W-1:0] mwb_dst_i,
  input  logic [W-1:0]    mwb_data_i,
  output logic [W-1:0]    val_o
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = en_i
    & hit(exm_wb_en_i & ~exm_mem_rd_i,
          exm_dst_i, addr_i);
  assign mwb_hit = en_i
    & hit(mwb_wb_en_i, mwb_dst_i, addr_i);

  // Both producers may match; the younger one wins.
  always_comb begin
    val_o = reg_i;
    priority case (1'b1)
      exm_hit: val_o = exm_res_i;
      mwb_hit: val_o = mwb_data_i;
      default: val_o = reg_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU
// and load-use hazard detection for the hazard unit.
module id_ex_stage
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic            id_src1_en,
  input  logic            id_src2_en,
  input  logic [RA_W-1:0] id_src1_addr,
  input  logic [RA_W-1:0] id_src2_addr,
  input  logic [RA_W-1:0] id_dst_addr,
  input  logic [W-1:0]    id_src1_val,
  input  logic [W-1:0]    id_src2_val,
  input  logic [W-1:0]    id_imm,
  input  logic            id_use_imm,
  input  logic [OP_W-1:0] id_alu_op,
  input  logic            id_wb_en,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic            id_flags_en,
  input  logic            exm_wb_en,
  input  logic            exm_mem_rd,
  input  logic [RA_W-1:0] exm_dst_addr,
  input  logic [W-1:0]    exm_result,
  input  logic            mwb_wb_en,
  input  logic [RA_W-1:0] mwb_dst_addr,
  input  logic [W-1:0]    mwb_data,
  output logic [W-1:0]    alu_in1,
  output logic [W-1:0]    alu_in2,
  output logic [OP_W-1:0] alu_op,
  output logic            ex_valid,
  output logic            ex_wb_en,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_flags_en,
  output logic [RA_W-1:0] ex_dst_addr,
  output logic [W-1:0]    ex_store_data,
  output logic            load_use_hazard
);

  id_ex_t       ex_q, ex_d;
  logic [W-1:0] fwd1, fwd2;

  fwd_sel u_fwd1 (
    .en_i         (ex_q.ctrl.valid & ex_q.src1_en),
    .addr_i       (ex_q.src1_addr),
    .reg_i        (ex_q.s1),
    .exm_wb_en_i  (exm_wb_en),
    .exm_mem_rd_i (exm_mem_rd),
    .exm_dst_i    (exm_dst_addr),
    .exm_res_i    (exm_result),
    .mwb_wb_en_i  (mwb_wb_en),
    .mwb_dst_i    (mwb_dst_addr),
    .mwb_data_i   (mwb_data),
    .val_o        (fwd1)
  );

  fwd_sel u_fwd2 (
    .en_i         (ex_q.ctrl.valid & ex_q.src2_en),
    .addr_i       (ex_q.src2_addr),
    .reg_i        (ex_q.s2),
    .exm_wb_en_i  (exm_wb_en),
    .exm_mem_rd_i (exm_mem_rd),
    .exm_dst_i    (exm_dst_addr),
    .exm_res_i    (exm_result),
    .mwb_wb_en_i  (mwb_wb_en),
    .mwb_dst_i    (mwb_dst_addr),
    .mwb_data_i   (mwb_data),
    .val_o        (fwd2)
  );

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      // Keep the forwarded value so a producer
      // retiring during the stall is not lost.
      ex_d.s1 = fwd1;
      ex_d.s2 = fwd2;
    end else begin
      ex_d.ctrl.valid    = id_valid;
      ex_d.ctrl.wb_en    = id_wb_en;
      ex_d.ctrl.mem_rd   = id_mem_rd;
      ex_d.ctrl.mem_wr   = id_mem_wr;
      ex_d.ctrl.flags_en = id_flags_en;
      ex_d.alu_op        = id_alu_op;
      ex_d.use_imm       = id_use_imm;
      ex_d.src1_en       = id_src1_en;
      ex_d.src2_en       = id_src2_en;
      ex_d.src1_addr     = id_src1_addr;
      ex_d.src2_addr     = id_src2_addr;
      ex_d.dst_addr      = id_dst_addr;
      ex_d.imm           = id_imm;
      ex_d.s1 = hit(mwb_wb_en, mwb_dst_addr,
                    id_src1_addr)
                ? mwb_data : id_src1_val;
      ex_d.s2 = hit(mwb_wb_en, mwb_dst_addr,
                    id_src2_addr)
                ? mwb_data : id_src2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign alu_in1       = fwd1;
  assign alu_in2       = ex_q.use_imm ? ex_q.imm : fwd2;
  assign ex_store_data = fwd2;
  assign alu_op        = ex_q.alu_op;
  assign ex_valid      = ex_q.ctrl.valid;
  assign ex_wb_en      = ex_q.ctrl.wb_en;
  assign ex_mem_rd     = ex_q.ctrl.mem_rd;
  assign ex_mem_wr     = ex_q.ctrl.mem_wr;
  assign ex_flags_en   = ex_q.ctrl.flags_en;
  assign ex_dst_addr   = ex_q.dst_addr;

  assign load_use_hazard = ~rst
    & ex_q.ctrl.valid & ex_q.ctrl.mem_rd & id_valid
    & (hit(id_src1_en, id_src1_addr, ex_q.dst_addr)
     | hit(id_src2_en, id_src2_addr, ex_q.dst_addr));

endmodule
